rotate_amount_finder: RTL
=========================

# rotate_amount_finder

Sequential inverse of the 8-bit rotate datapath. Given an original byte and a rotated byte, it searches one rotation step per clock for the rotation that maps the original onto the rotated value. It reports that rotation as a `move`/`direction` pair in the same encoding the rotator consumes (`direction` 1 = right, 0 = left; `move` 0–7). It sits on the receive/check side of the lab datapath and recovers the rotate command from observed data.

## Interface
- No parameters; width fixed at 8 bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a search; sampled only in IDLE.
- `original` input 8: unrotated byte; captured on the accepted `start` cycle.
- `rotated` input 8: target byte; captured on the accepted `start` cycle.
- `busy` output 1: high while in SEARCH.
- `done` output 1: one-cycle pulse when the result is valid.
- `found` output 1: 1 if a matching rotation exists.
- `move` output 3: recovered rotation amount.
- `direction` output 1: recovered direction, 1 = right, 0 = left.

## Operation
- Decided: one clock (`clk`); reset `rst` is synchronous and active-high.
- States: IDLE, SEARCH, DONE. Reset state is IDLE.
- Internal registers:
  - `cand[7:0]`: candidate rotation of `original`.
  - `tgt[7:0]`: captured `rotated`.
  - `k[2:0]`: current left-rotation step.
- IDLE, `start`=1: capture `cand`←`original`, `tgt`←`rotated`, `k`←0, go to SEARCH.
- IDLE, `start`=0: remain in IDLE.
- SEARCH, each cycle:
  - `cand`==`tgt`: register the result with `found`=1, go to DONE.
  - Else if `k`==7: `found`=0, `move`=0, `direction`=0, go to DONE.
  - Else: `cand`←`cand` rotated left by 1 (`{cand[6:0],cand[7]}`), `k`←`k`+1, stay in SEARCH.
- Result encoding, minimal magnitude with the first match winning (smallest `k`):
  - `k` ≤ 4: `direction`=0, `move`=`k`.
  - `k` ≥ 5: `direction`=1, `move`=8−`k`.
  - `k`=4 reports left. `k`=0 reports `move`=0, `direction`=0.
- DONE: `done`=1 for exactly this cycle, then unconditionally go to IDLE.
- `start` is ignored in SEARCH and DONE; no queueing.
- `found`, `move` and `direction` hold their value until the next result is registered. They do not change when a new `start` is accepted.
- Inputs `original`/`rotated` may change freely after the accepted `start` cycle.
- Periodic patterns (e.g. 0x00, 0xFF, 0x55) match at `k`=0 and report `move`=0, `direction`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `found`=0, `move`=0, `direction`=0; state IDLE; `cand`, `tgt`, `k` cleared.
- `start` accepted at edge t: `busy`=1 from cycle t+1.
- Step `k` is compared in cycle t+1+`k`.
- Match at step `k`: `done`=1 and new result visible in cycle t+2+`k`, with `busy`=0 in that cycle.
- Latency: minimum 2 cycles (`k`=0); maximum 9 cycles (no match after `k`=7).
- Earliest next accepted `start` is the cycle after `done`, so back-to-back throughput is one search per (latency+1) cycles.
- `rst` asserted in any state, including mid-SEARCH or during DONE, takes priority: at the next edge all outputs and registers reach reset values with no `done` pulse. `start` is ignored in the cycle `rst` is high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `original`=0x81, `rotated`=0x0C, pulse `start` at t → `done` at t+5 with `found`=1, `move`=3, `direction`=0; `busy` high t+1..t+4.
- `original`=0x81, `rotated`=0x60 (right 2) → `done` at t+8 with `found`=1, `move`=2, `direction`=1.
- `original`=0x01, `rotated`=0x03 → `done` at t+9 with `found`=0, `move`=0, `direction`=0.
- `original`=0x55, `rotated`=0x55, then `original`=0xF0, `rotated`=0x0F → first: `done` at t+2, `move`=0, `direction`=0; second: `move`=4, `direction`=0.
- Hold `start` high for 12 cycles with `original`=0x81, `rotated`=0x0C → exactly one search, `done` at t+5, second search accepted at t+6.
- Start a 0x01→0x03 search, assert `rst` at t+4 → at t+5 all outputs are 0 and the state is IDLE; no `done` pulse ever appears for that search.

Source files
------------

// File: rtl/rotate_amount_finder.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_amount_finder
//  Purpose  : Recovers the move/direction pair of an 8-bit rotation by
//             stepping a left-rotated candidate one position per clock.
//  Revision : 1.0
// ============================================================================
module rotate_amount_finder (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] original,
   input  logic [7:0] rotated,
   output logic       busy,
   output logic       done,
   output logic       found,
   output logic [2:0] move,
   output logic       direction
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] cand_q, cand_d;
   logic [7:0] tgt_q, tgt_d;
   logic [2:0] k_q, k_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       found_q, found_d;
   logic [2:0] move_q, move_d;
   logic       direction_q, direction_d;

   logic       w_match;
   logic       w_last_step;

   assign w_match     = (cand_q == tgt_q);
   assign w_last_step = (k_q == 3'd7);

   // State register and all datapath/output flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cand_q      <= 8'h00;
         tgt_q       <= 8'h00;
         k_q         <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         move_q      <= 3'd0;
         direction_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         tgt_q       <= tgt_d;
         k_q         <= k_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         found_q     <= found_d;
         move_q      <= move_d;
         direction_q <= direction_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (w_match || w_last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      cand_d      = cand_q;
      tgt_d       = tgt_q;
      k_d         = k_q;
      found_d     = found_q;
      move_d      = move_q;
      direction_d = direction_q;
      busy_d      = (state_d == S_SEARCH);
      done_d      = (state_d == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cand_d = original;
               tgt_d  = rotated;
               k_d    = 3'd0;
            end
         end
         S_SEARCH: begin
            if (w_match) begin
               found_d = 1'b1;
               // Left steps above 4 are reported as the shorter right rotation
               if (k_q <= 3'd4) begin
                  direction_d = 1'b0;
                  move_d      = k_q;
               end else begin
                  direction_d = 1'b1;
                  move_d      = ~k_q + 3'd1;
               end
            end else if (w_last_step) begin
               found_d     = 1'b0;
               move_d      = 3'd0;
               direction_d = 1'b0;
            end else begin
               cand_d = {cand_q[6:0], cand_q[7]};
               k_d    = k_q + 3'd1;
            end
         end
         default: begin
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign found     = found_q;
   assign move      = move_q;
   assign direction = direction_q;

endmodule
`default_nettype wire
